// File: rtl/aud_clip_scheduler_if.sv
// Player-side handshake between the clip scheduler (master) and the audio clip player (slave).
interface aud_clip_scheduler_if;
  logic [1:0] o_sound_index;
  logic       o_start;
  logic       o_stop;
  logic       i_playing;
  logic       i_play_done;

  modport master (
    output o_sound_index, o_start, o_stop,
    input  i_playing, i_play_done
  );

  modport slave (
    input  o_sound_index, o_start, o_stop,
    output i_playing, i_play_done
  );
endinterface

// File: rtl/aud_clip_scheduler.sv
// Audio clip scheduler: arbitrates clip requests by fixed priority and sequences start/ack/play/gap.
// Define AUD_SCHED_PREEMPT_EN to let a higher-priority request stop the clip that is playing.
module aud_clip_scheduler #(
  parameter int GAP_CYCLES  = 1024,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_init_done,
  input  logic [3:0]                    i_req,
  input  logic                          i_bg_en,
  output logic                          o_busy,
  output logic [3:0]                    o_pending,
  aud_clip_scheduler_if.master          player
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_TC   = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_START, S_WAIT_ACK, S_PLAY, S_STOP, S_DRAIN, S_GAP
  } state_t;

  state_t           state;
  logic [3:0]       pending;
  logic [3:0]       clr_mask;
  logic [3:0]       bg_set;
  logic [1:0]       sound_index;
  logic             start_q;
  logic             stop_q;
  logic [ACK_W-1:0] ack_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // DIE(3) > WIN(2) > KILL(1) > GAME(0)
  function automatic logic [1:0] top_prio(input logic [3:0] p);
    if (p[3])      return 2'd3;
    else if (p[2]) return 2'd2;
    else if (p[1]) return 2'd1;
    return 2'd0;
  endfunction

`ifdef AUD_SCHED_PREEMPT_EN
  function automatic logic outranks(input logic [3:0] p, input logic [1:0] idx);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 4; k++)
      if (p[k] && (k > int'(idx))) r = 1'b1;
    return r;
  endfunction
`endif

  // Grant clears its bit while a same-cycle request for that clip re-sets it.
  always_comb begin
    clr_mask = '0;
    bg_set   = '0;
    if (state == S_IDLE) begin
      if (|pending)     clr_mask = 4'b0001 << top_prio(pending);
      else if (i_bg_en) bg_set   = 4'b0001;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_INIT;
      pending     <= '0;
      sound_index <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      ack_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | i_req | bg_set;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      case (state)
        S_INIT: if (i_init_done) state <= S_IDLE;
        S_IDLE: begin
          if (|pending) begin
            sound_index <= top_prio(pending);
            start_q     <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          ack_cnt <= '0;
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (player.i_playing) begin
            state <= S_PLAY;
          end else if (ack_cnt == ACK_LAST) begin
            start_q <= 1'b1;
            state   <= S_START;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        // Clip completion outranks preemption when both land in the same cycle.
        S_PLAY: begin
          if (player.i_play_done || !player.i_playing) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
`ifdef AUD_SCHED_PREEMPT_EN
          else if (outranks(pending, sound_index)) begin
            stop_q <= 1'b1;
            state  <= S_STOP;
          end
`endif
        end
        S_STOP: state <= S_DRAIN;
        S_DRAIN: begin
          if (!player.i_playing) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt != GAP_TC) gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign player.o_sound_index = sound_index;
  assign player.o_start       = start_q;
  assign player.o_stop        = stop_q;
  assign o_busy               = (state != S_INIT) && (state != S_IDLE);
  assign o_pending            = pending;

endmodule

// File: doc/aud_clip_scheduler.md
AUD_CLIP_SCHEDULER -- requirements
Module: aud_clip_scheduler

Interface
REQ-001 The module SHALL have parameter GAP_CYCLES, default 1024: idle cycles inserted between consecutive clips.
REQ-002 The module SHALL have parameter ACK_TIMEOUT, default 16: cycles allowed for the player to report playing after a start pulse.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 i_clk  in  1  system clock; all logic on rising edge.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_init_done  in  1  codec I2C initialisation finished (level).
REQ-007 i_req  in  4  one-cycle request pulses; bit k requests clip k (0 GAME, 1 KILL, 2 WIN, 3 DIE).
REQ-008 i_bg_en  in  1  background enable; when high, GAME auto-requeues whenever nothing else is pending.
REQ-009 i_playing  in  1  player is in its play state (level).
REQ-010 i_play_done  in  1  end-of-clip pulse from the player (finish address reached).
REQ-011 o_sound_index  out  2  clip selected for the player; held stable from start until the next grant.
REQ-012 o_start  out  1  one-cycle start pulse to the player.
REQ-013 o_stop  out  1  one-cycle stop pulse to the player.
REQ-014 o_busy  out  1  high in every state except S_INIT and S_IDLE.
REQ-015 o_pending  out  4  current pending-request register.

Function
REQ-016 States SHALL be S_INIT, S_IDLE, S_START, S_WAIT_ACK, S_PLAY, S_STOP, S_DRAIN and S_GAP.
REQ-017 S_INIT SHALL be held until i_init_done=1, then go to S_IDLE next cycle.
REQ-018 Each i_req bit SHALL set its pending bit; the bit stays set until granted.
REQ-019 Grant priority SHALL be DIE > WIN > KILL > GAME, fixed.
REQ-020 S_IDLE with any pending bit set: latch the highest-priority index into o_sound_index, clear that pending bit, and go to S_START.
REQ-021 If a request for the granted clip arrives in the grant cycle, set SHALL win and the pending bit SHALL remain 1.
REQ-022 S_START SHALL assert o_start for exactly one cycle, then go to S_WAIT_ACK with a timeout counter at 0.
REQ-023 S_WAIT_ACK: i_playing=1 -> S_PLAY; counter reaching ACK_TIMEOUT-1 -> S_START (retry, unlimited).
REQ-024 S_PLAY: i_play_done=1 or i_playing=0 -> S_GAP with the gap counter at 0.
REQ-025 In S_GAP the gap counter SHALL count GAP_CYCLES cycles, then go to S_IDLE; requests are still captured during the gap.
REQ-026 In S_IDLE with pending=0 and i_bg_en=1, GAME's pending bit SHALL be set that cycle and granted the following cycle.
REQ-027 The GAP counter SHALL be sized ceil(log2(GAP_CYCLES+1)) bits and saturate at its terminal count; it SHALL NOT wrap.
REQ-028 If i_play_done and a preempting request occur in the same cycle, completion SHALL take precedence: go to S_GAP with no o_stop.
REQ-029 o_start and o_stop SHALL never be high in the same cycle.

Reset
REQ-030 Reset SHALL force S_INIT; o_start=0, o_stop=0, o_sound_index=0, o_busy=0, o_pending=0, and all counters 0.
REQ-031 Reset mid-clip SHALL NOT emit o_stop; the player is reset by its own reset.
REQ-032 After reset deassertion the block SHALL wait for i_init_done again.

Configuration
REQ-033 Macro AUD_SCHED_PREEMPT_EN SHALL compile preemption in or out.
REQ-034 With AUD_SCHED_PREEMPT_EN defined: in S_PLAY, a pending clip of strictly higher priority than o_sound_index -> S_STOP.
  - S_STOP pulses o_stop for one cycle, then goes to S_DRAIN.
  - S_DRAIN waits for i_playing=0, then goes to S_GAP.
  - The preempted clip is discarded, not requeued.
REQ-035 Without AUD_SCHED_PREEMPT_EN: S_STOP and S_DRAIN SHALL be unreachable, o_stop is constant 0, and higher-priority requests wait for clip end.

Verification
REQ-036 Pulse i_req=4'b0010 after init, player echoes i_playing 2 cycles after o_start -> o_sound_index=1, o_start one cycle, o_busy=1 until GAP_CYCLES after i_play_done.
REQ-037 i_req=4'b1111 in one cycle -> grants in order 3,2,1,0, each separated by a gap of GAP_CYCLES.
REQ-038 i_playing held 0 after o_start -> o_start re-pulses every ACK_TIMEOUT+1 cycles (17 with default).
REQ-039 PREEMPT_EN, GAME playing, i_req=4'b1000 -> o_stop one cycle, wait for i_playing=0, gap, then o_sound_index=3 with o_start; GAME's pending bit =0 while i_bg_en=0.
REQ-040 i_bg_en=1, no requests -> GAME granted repeatedly, with GAP_CYCLES between each i_play_done and the next o_start.
REQ-041 i_rst=1 in S_PLAY -> next cycle all outputs 0, o_stop never asserted, state S_INIT, no o_start until i_init_done.
